// File: rtl/dmni_dma_sched.sv
// Descriptor scheduler for the DMNI DMA: two descriptor FIFOs, round-robin issue onto
// the shared configuration bus, and per-direction completion tracking with a sticky IRQ.
module dmni_dma_sched #(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_dir_i,
  input  logic [31:0]             cmd_addr_i,
  input  logic [31:0]             cmd_addr_2_i,
  input  logic [31:0]             cmd_size_i,
  input  logic [31:0]             cmd_size_2_i,
  output logic                    cmd_err_o,
  output logic                    hermes_st_snd_o,
  output logic                    hermes_st_rcv_o,
  output logic [31:0]             hermes_address_o,
  output logic [31:0]             hermes_address_2_o,
  output logic [31:0]             hermes_size_o,
  output logic [31:0]             hermes_size_2_o,
  input  logic                    hermes_send_active_i,
  input  logic                    hermes_receive_active_i,
  input  logic                    hermes_receive_available_i,
  output logic                    done_snd_o,
  output logic                    done_rcv_o,
  output logic                    irq_o,
  input  logic                    irq_ack_i,
  output logic [$clog2(DEPTH):0]  snd_count_o,
  output logic [$clog2(DEPTH):0]  rcv_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic DIR_SND = 1'b0;
  localparam logic DIR_RCV = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, START = 2'd2} state_e;

  // Returns {busy, seen, done}: busy arms on issue, seen once the DMA reports activity,
  // and completion is the first idle sample after activity was seen.
  function automatic logic [2:0] track_xfer(input logic pop, input logic busy,
                                            input logic seen, input logic active);
    logic [2:0] r;
    if (pop) r = 3'b100;
    else if (busy && seen && !active) r = 3'b001;
    else if (busy && active) r = 3'b110;
    else r = {busy, seen, 1'b0};
    return r;
  endfunction

  state_e state_q, state_d;
  logic grant_q, grant_d, last_grant_q, last_grant_d;
  logic [31:0] snd_addr_q [DEPTH];
  logic [31:0] snd_addr2_q [DEPTH];
  logic [31:0] snd_size_q [DEPTH];
  logic [31:0] snd_size2_q [DEPTH];
  logic [31:0] rcv_addr_q [DEPTH];
  logic [31:0] rcv_size_q [DEPTH];
  logic [AW-1:0] snd_wp_q, snd_rp_q, rcv_wp_q, rcv_rp_q;
  logic [CW-1:0] snd_cnt_q, snd_cnt_d, rcv_cnt_q, rcv_cnt_d;
  logic snd_busy_q, snd_seen_q, rcv_busy_q, rcv_seen_q;
  logic snd_busy_d, snd_seen_d, rcv_busy_d, rcv_seen_d;
  logic done_snd_q, done_snd_d, done_rcv_q, done_rcv_d;
  logic irq_q, irq_d, err_q;
  logic st_snd_q, st_snd_d, st_rcv_q, st_rcv_d;
  logic [31:0] addr_q, addr_d, addr2_q, addr2_d, size_q, size_d, size2_q, size2_d;
  logic [32:0] snd_sum_s;
  logic legal_s, push_snd_s, push_rcv_s, pop_snd_s, pop_rcv_s, elig_snd_s, elig_rcv_s;

  // Push qualification: readiness depends only on the registered occupancy
  always_comb begin
    snd_sum_s   = {1'b0, cmd_size_i} + {1'b0, cmd_size_2_i};
    cmd_ready_o = cmd_dir_i ? (rcv_cnt_q != FULL_CNT) : (snd_cnt_q != FULL_CNT);
    legal_s     = cmd_dir_i ? (cmd_size_i != 32'd0) : (snd_sum_s != 33'd0);
    push_snd_s  = cmd_valid_i && cmd_ready_o && legal_s && (cmd_dir_i == DIR_SND);
    push_rcv_s  = cmd_valid_i && cmd_ready_o && legal_s && (cmd_dir_i == DIR_RCV);
    elig_snd_s  = (snd_cnt_q != {CW{1'b0}}) && !snd_busy_q;
    elig_rcv_s  = (rcv_cnt_q != {CW{1'b0}}) && !rcv_busy_q && hermes_receive_available_i;
  end

  // Descriptor storage, written at the tail on accepted pushes
  always_ff @(posedge clk_i) begin
    if (push_snd_s) begin
      snd_addr_q[snd_wp_q]  <= cmd_addr_i;
      snd_addr2_q[snd_wp_q] <= cmd_addr_2_i;
      snd_size_q[snd_wp_q]  <= cmd_size_i;
      snd_size2_q[snd_wp_q] <= cmd_size_2_i;
    end
    if (push_rcv_s) begin
      rcv_addr_q[rcv_wp_q] <= cmd_addr_i;
      rcv_size_q[rcv_wp_q] <= cmd_size_i;
    end
  end

  // Occupancy next state: a push and a pop in the same cycle cancel out
  always_comb begin
    case ({push_snd_s, pop_snd_s})
      2'b10:   snd_cnt_d = snd_cnt_q + CNT_ONE;
      2'b01:   snd_cnt_d = snd_cnt_q - CNT_ONE;
      default: snd_cnt_d = snd_cnt_q;
    endcase
    case ({push_rcv_s, pop_rcv_s})
      2'b10:   rcv_cnt_d = rcv_cnt_q + CNT_ONE;
      2'b01:   rcv_cnt_d = rcv_cnt_q - CNT_ONE;
      default: rcv_cnt_d = rcv_cnt_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= DIR_SND;
      last_grant_q <= DIR_RCV;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // FSM next state; a tie goes to the direction not served last
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (elig_snd_s || elig_rcv_s) begin
          state_d = SETUP;
          if (elig_snd_s && elig_rcv_s) grant_d = ~last_grant_q;
          else grant_d = elig_rcv_s ? DIR_RCV : DIR_SND;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:   state_d = START;
      START:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: head pop at the end of START, next values of strobes and config bus
  always_comb begin
    pop_snd_s    = (state_q == START) && (grant_q == DIR_SND);
    pop_rcv_s    = (state_q == START) && (grant_q == DIR_RCV);
    last_grant_d = (state_q == START) ? grant_q : last_grant_q;
    st_snd_d     = (state_d == START) && (grant_d == DIR_SND);
    st_rcv_d     = (state_d == START) && (grant_d == DIR_RCV);
    if (state_d == IDLE) begin
      addr_d = 32'd0; addr2_d = 32'd0; size_d = 32'd0; size2_d = 32'd0;
    end else if (grant_d == DIR_SND) begin
      addr_d  = snd_addr_q[snd_rp_q];
      addr2_d = snd_addr2_q[snd_rp_q];
      size_d  = snd_size_q[snd_rp_q];
      size2_d = snd_size2_q[snd_rp_q];
    end else begin
      addr_d = rcv_addr_q[rcv_rp_q]; addr2_d = 32'd0;
      size_d = rcv_size_q[rcv_rp_q]; size2_d = 32'd0;
    end
  end

  // Completion tracking and interrupt next state
  always_comb begin
    {snd_busy_d, snd_seen_d, done_snd_d} = track_xfer(pop_snd_s, snd_busy_q, snd_seen_q,
                                                      hermes_send_active_i);
    {rcv_busy_d, rcv_seen_d, done_rcv_d} = track_xfer(pop_rcv_s, rcv_busy_q, rcv_seen_q,
                                                      hermes_receive_active_i);
    if (done_snd_q || done_rcv_q) irq_d = 1'b1;
    else if (irq_ack_i) irq_d = 1'b0;
    else irq_d = irq_q;
  end

  // Pointers, counts, tracking flags and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snd_wp_q <= '0; snd_rp_q <= '0; rcv_wp_q <= '0; rcv_rp_q <= '0;
      snd_cnt_q <= '0; rcv_cnt_q <= '0;
      snd_busy_q <= 1'b0; snd_seen_q <= 1'b0; rcv_busy_q <= 1'b0; rcv_seen_q <= 1'b0;
      done_snd_q <= 1'b0; done_rcv_q <= 1'b0; irq_q <= 1'b0; err_q <= 1'b0;
      st_snd_q <= 1'b0; st_rcv_q <= 1'b0;
      addr_q <= 32'd0; addr2_q <= 32'd0; size_q <= 32'd0; size2_q <= 32'd0;
    end else begin
      if (push_snd_s) snd_wp_q <= snd_wp_q + PTR_ONE;
      if (pop_snd_s)  snd_rp_q <= snd_rp_q + PTR_ONE;
      if (push_rcv_s) rcv_wp_q <= rcv_wp_q + PTR_ONE;
      if (pop_rcv_s)  rcv_rp_q <= rcv_rp_q + PTR_ONE;
      snd_cnt_q <= snd_cnt_d; rcv_cnt_q <= rcv_cnt_d;
      snd_busy_q <= snd_busy_d; snd_seen_q <= snd_seen_d;
      rcv_busy_q <= rcv_busy_d; rcv_seen_q <= rcv_seen_d;
      done_snd_q <= done_snd_d; done_rcv_q <= done_rcv_d; irq_q <= irq_d;
      err_q <= cmd_valid_i && cmd_ready_o && !legal_s;
      st_snd_q <= st_snd_d; st_rcv_q <= st_rcv_d;
      addr_q <= addr_d; addr2_q <= addr2_d; size_q <= size_d; size2_q <= size2_d;
    end
  end

  assign cmd_err_o          = err_q;
  assign hermes_st_snd_o    = st_snd_q;
  assign hermes_st_rcv_o    = st_rcv_q;
  assign hermes_address_o   = addr_q;
  assign hermes_address_2_o = addr2_q;
  assign hermes_size_o      = size_q;
  assign hermes_size_2_o    = size2_q;
  assign done_snd_o         = done_snd_q;
  assign done_rcv_o         = done_rcv_q;
  assign irq_o              = irq_q;
  assign snd_count_o        = snd_cnt_q;
  assign rcv_count_o        = rcv_cnt_q;
endmodule

// File: tb/tb_dmni_dma_sched.sv
// Directed and randomized bench for dmni_dma_sched with a transaction-level FIFO model.
module tb_dmni_dma_sched;
  localparam int DEPTH = 4;

  typedef struct packed {logic [31:0] a; logic [31:0] a2; logic [31:0] s; logic [31:0] s2;} desc_t;
  typedef struct packed {logic d; desc_t x;} ev_t;

  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, dir = 1'b0, snd_act = 1'b0, rcv_act = 1'b0, avail = 1'b0, ack = 1'b0;
  logic [31:0] addr_in = 32'd0, addr2_in = 32'd0, size_in = 32'd0, size2_in = 32'd0;
  logic ready, err, st_snd, st_rcv, done_snd, done_rcv, irq;
  logic [31:0] h_addr, h_addr2, h_size, h_size2;
  logic [2:0] snd_cnt, rcv_cnt;

  int checks = 0, errors = 0;
  int st_snd_n = 0, st_rcv_n = 0, done_snd_n = 0, done_rcv_n = 0;
  ev_t log_q[$];
  desc_t qs[$], qr[$];

  dmni_dma_sched #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready), .cmd_dir_i(dir),
    .cmd_addr_i(addr_in), .cmd_addr_2_i(addr2_in), .cmd_size_i(size_in), .cmd_size_2_i(size2_in),
    .cmd_err_o(err), .hermes_st_snd_o(st_snd), .hermes_st_rcv_o(st_rcv),
    .hermes_address_o(h_addr), .hermes_address_2_o(h_addr2), .hermes_size_o(h_size),
    .hermes_size_2_o(h_size2), .hermes_send_active_i(snd_act), .hermes_receive_active_i(rcv_act),
    .hermes_receive_available_i(avail), .done_snd_o(done_snd), .done_rcv_o(done_rcv),
    .irq_o(irq), .irq_ack_i(ack), .snd_count_o(snd_cnt), .rcv_count_o(rcv_cnt)
  );

  always #5 clk = ~clk;

  // Issue and completion monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (st_snd) begin log_q.push_back({1'b0, h_addr, h_addr2, h_size, h_size2}); st_snd_n <= st_snd_n + 1; end
    if (st_rcv) begin log_q.push_back({1'b1, h_addr, h_addr2, h_size, h_size2}); st_rcv_n <= st_rcv_n + 1; end
    if (done_snd) done_snd_n <= done_snd_n + 1;
    if (done_rcv) done_rcv_n <= done_rcv_n + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic d, input logic [31:0] a, input logic [31:0] a2,
                      input logic [31:0] s, input logic [31:0] s2);
    valid = 1'b1; dir = d; addr_in = a; addr2_in = a2; size_in = s; size2_in = s2;
    tick();
    valid = 1'b0;
  endtask

  task automatic chk_ev(input string tag, input logic d, input desc_t x);
    ev_t e;
    chk({tag, "_present"}, 128'(log_q.size() > 0), 128'(1));
    e = (log_q.size() > 0) ? log_q.pop_front() : '0;
    chk({tag, "_dir"}, 128'(e.d), 128'(d));
    chk({tag, "_desc"}, e.x, x);
  endtask

  task automatic chk_idle_outputs(input string tag);
    dir = 1'b0; #1;
    chk({tag, "_ready"}, 128'(ready), 128'(1));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_strobes"}, 128'({st_snd, st_rcv}), 128'(0));
    chk({tag, "_bus"}, {h_addr, h_addr2, h_size, h_size2}, 128'(0));
    chk({tag, "_done_irq"}, 128'({done_snd, done_rcv, irq}), 128'(0));
    chk({tag, "_counts"}, 128'({snd_cnt, rcv_cnt}), 128'(0));
  endtask

  initial begin
    int base, s_left, r_left, sn0, rn0;
    logic exp_ready, legal;
    ev_t e;
    desc_t ex;

    // Reset state
    repeat (2) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single send: strobe two edges after the push edge, count drops one edge later
    base = done_snd_n;
    push(1'b0, 32'h100, 32'h0, 32'd4, 32'd0);
    chk("snd_count_after_push", 128'(snd_cnt), 128'(1));
    tick(); chk("snd_setup_no_strobe", 128'(st_snd), 128'(0));
    tick(); chk("snd_strobe", 128'(st_snd), 128'(1));
    chk("snd_bus", {h_addr, h_addr2, h_size, h_size2}, {32'h100, 32'h0, 32'd4, 32'd0});
    tick(); chk("snd_strobe_one_cycle", 128'(st_snd), 128'(0));
    chk("snd_count_after_pop", 128'(snd_cnt), 128'(0));
    chk("snd_bus_idle", 128'(h_addr), 128'(0));
    snd_act = 1'b1; repeat (5) tick(); snd_act = 1'b0;
    tick(); chk("snd_done", 128'({done_snd, irq}), 128'(2'b10));
    tick(); chk("snd_irq", 128'({done_snd, irq}), 128'(2'b01));
    tick(); chk("snd_irq_sticky", 128'(irq), 128'(1));
    chk("snd_done_once", 128'(done_snd_n - base), 128'(1));
    ack = 1'b1; tick(); ack = 1'b0;
    chk("snd_irq_ack", 128'(irq), 128'(0));
    log_q.delete();

    // Receive gated by availability
    base = st_rcv_n;
    push(1'b1, 32'h200, 32'h0, 32'd8, 32'd0);
    repeat (10) tick();
    chk("rcv_gated", 128'(st_rcv_n - base), 128'(0));
    avail = 1'b1;
    tick(); chk("rcv_setup", 128'(st_rcv), 128'(0));
    tick(); chk("rcv_strobe", 128'(st_rcv), 128'(1));
    chk("rcv_bus", {h_addr, h_addr2, h_size, h_size2}, {32'h200, 32'h0, 32'd8, 32'd0});
    rcv_act = 1'b1; repeat (2) tick(); rcv_act = 1'b0;
    tick(); chk("rcv_done", 128'(done_rcv), 128'(1));
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    log_q.delete();

    // Concurrent transfers, simultaneous completion under ack, then tie round-robin
    snd_act = 1'b1; rcv_act = 1'b1;
    push(1'b0, 32'h300, 32'h301, 32'd1, 32'd2);
    push(1'b1, 32'h400, 32'h0, 32'd3, 32'd0);
    push(1'b0, 32'h310, 32'h311, 32'd5, 32'd6);
    push(1'b0, 32'h320, 32'h321, 32'd7, 32'd0);
    push(1'b1, 32'h410, 32'h0, 32'd9, 32'd0);
    push(1'b1, 32'h420, 32'h0, 32'd11, 32'd0);
    repeat (6) tick();
    chk("both_queues_two", 128'({snd_cnt, rcv_cnt}), 128'({3'd2, 3'd2}));
    snd_act = 1'b0; rcv_act = 1'b0; ack = 1'b1;
    tick(); chk("both_done_same_cycle", 128'({done_snd, done_rcv}), 128'(2'b11));
    tick(); chk("irq_set_beats_ack", 128'(irq), 128'(1));
    ack = 1'b0; snd_act = 1'b1; rcv_act = 1'b1;
    repeat (8) tick();
    snd_act = 1'b0; rcv_act = 1'b0;
    repeat (2) tick();
    snd_act = 1'b1; rcv_act = 1'b1;
    repeat (8) tick();
    snd_act = 1'b0; rcv_act = 1'b0;
    repeat (3) tick();
    chk_ev("rr0", 1'b0, {32'h300, 32'h301, 32'd1, 32'd2});
    chk_ev("rr1", 1'b1, {32'h400, 32'h0, 32'd3, 32'd0});
    chk_ev("rr2", 1'b0, {32'h310, 32'h311, 32'd5, 32'd6});
    chk_ev("rr3", 1'b1, {32'h410, 32'h0, 32'd9, 32'd0});
    chk_ev("rr4", 1'b0, {32'h320, 32'h321, 32'd7, 32'd0});
    chk_ev("rr5", 1'b1, {32'h420, 32'h0, 32'd11, 32'd0});
    ack = 1'b1; tick(); ack = 1'b0;

    // Full queue, illegal descriptors and the 33-bit size sum
    rst = 1'b1; tick(); rst = 1'b0; log_q.delete();
    push(1'b0, 32'h500, 32'h501, 32'hFFFF_FFFF, 32'd1);
    chk("wrap_sum_legal", 128'(err), 128'(0));
    push(1'b0, 32'h510, 32'h511, 32'd0, 32'd0);
    chk("illegal_err", 128'(err), 128'(1));
    chk("illegal_count", 128'(snd_cnt), 128'(1));
    for (int i = 0; i < 4; i++) push(1'b0, 32'h600 + 32'(i), 32'h0, 32'd1, 32'd0);
    tick();
    chk("full_count", 128'(snd_cnt), 128'(4));
    dir = 1'b0; #1; chk("full_not_ready", 128'(ready), 128'(0));
    dir = 1'b1; #1; chk("rcv_ready_while_snd_full", 128'(ready), 128'(1));
    push(1'b0, 32'h700, 32'h0, 32'd0, 32'd0);
    chk("full_illegal_no_err", 128'({err, snd_cnt}), 128'({1'b0, 3'd4}));
    push(1'b0, 32'h710, 32'h0, 32'd2, 32'd0);
    chk("full_push_dropped", 128'(snd_cnt), 128'(4));
    chk_ev("wrap_issue", 1'b0, {32'h500, 32'h501, 32'hFFFF_FFFF, 32'd1});

    // Reset while a send is in START with three entries queued
    rst = 1'b1; tick(); rst = 1'b0; log_q.delete();
    base = done_snd_n;
    push(1'b0, 32'h800, 32'h0, 32'd1, 32'd0);
    push(1'b0, 32'h810, 32'h0, 32'd1, 32'd0);
    push(1'b0, 32'h820, 32'h0, 32'd1, 32'd0);
    chk("pre_reset_start", 128'({st_snd, snd_cnt}), 128'({1'b1, 3'd3}));
    rst = 1'b1;
    chk_idle_outputs("mid_reset");
    tick(); rst = 1'b0;
    snd_act = 1'b1; repeat (3) tick(); snd_act = 1'b0; repeat (5) tick();
    chk("no_done_after_reset", 128'(done_snd_n - base), 128'(0));
    log_q.delete();

    // Randomized traffic against per-direction FIFO model with a responsive DMA
    s_left = 0; r_left = 0; sn0 = st_snd_n; rn0 = st_rcv_n;
    base = done_snd_n + done_rcv_n;
    for (int it = 0; it < 1500; it++) begin
      while (log_q.size() > 0) begin
        e = log_q.pop_front();
        if (e.d == 1'b0) begin
          ex = (qs.size() > 0) ? qs.pop_front() : '1;
          chk("rnd_snd_issue", e.x, ex);
          s_left = $urandom_range(1, 4);
        end else begin
          ex = (qr.size() > 0) ? qr.pop_front() : '1;
          chk("rnd_rcv_issue", e.x, ex);
          r_left = $urandom_range(1, 4);
        end
      end
      snd_act = (s_left > 0); if (s_left > 0) s_left--;
      rcv_act = (r_left > 0); if (r_left > 0) r_left--;
      chk("rnd_snd_count", 128'(snd_cnt), 128'(qs.size()));
      chk("rnd_rcv_count", 128'(rcv_cnt), 128'(qr.size()));
      valid    = (it < 1200) && ($urandom_range(0, 1) == 0);
      dir      = 1'($urandom_range(0, 1));
      addr_in  = $urandom; addr2_in = $urandom;
      size_in  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      size2_in = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      avail    = (it >= 1200) || ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = dir ? (qr.size() < DEPTH) : (qs.size() < DEPTH);
      legal = dir ? (size_in != 32'd0) : ((size_in != 32'd0) || (size2_in != 32'd0));
      chk("rnd_ready", 128'(ready), 128'(exp_ready));
      @(posedge clk); #1;
      chk("rnd_err", 128'(err), 128'(valid && exp_ready && !legal));
      if (valid && exp_ready && legal) begin
        if (dir) qr.push_back({addr_in, 32'd0, size_in, 32'd0});
        else qs.push_back({addr_in, addr2_in, size_in, size2_in});
      end
      valid = 1'b0;
    end
    repeat (4) tick();
    chk("rnd_drained", 128'(qs.size() + qr.size() + log_q.size()), 128'(0));
    chk("rnd_all_done", 128'(done_snd_n + done_rcv_n - base),
        128'(st_snd_n - sn0 + st_rcv_n - rn0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
